// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: FSM states, opcodes, ALU codes.
// Combinational helpers only; no latency or backpressure of its own.
package control_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    EXEC_R    = 4'd3,
    EXEC_I    = 4'd4,
    BRANCH    = 4'd5,
    EXEC_MULT = 4'd6,
    WB_R      = 4'd7,
    WB_I      = 4'd8
  } ctrlStateT;

  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] MULT   = 6'h01;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] BNE    = 6'h05;
  localparam logic [5:0] MOV    = 6'h06;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] ORI    = 6'h0D;

  localparam logic [2:0] ALU_NOP   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_MUL   = 3'b010;
  localparam logic [2:0] ALU_MOV   = 3'b011;
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  typedef struct packed {
    logic       pcWrite;
    logic       irWrite;
    logic       memRead;
    logic       memWrite;
    logic       regDst;
    logic       regWrite;
    logic       memtoReg;
    logic       aluSrcA;
    logic       pcSource;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic       busy;
    logic       instrDone;
    logic       illegal;
  } ctrlSigsT;

  // Unknown opcodes map to FETCH, which is also how the top flags them illegal.
  function automatic ctrlStateT decodeOp(input logic [5:0] op);
    case (op)
      R_TYPE, MOV: return EXEC_R;
      ADDI, ORI:   return EXEC_I;
      BEQ, BNE:    return BRANCH;
      MULT:        return EXEC_MULT;
      default:     return FETCH;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath signal bundle; master is the controller, slave the datapath side.
// Pure wiring: no latency, no backpressure beyond the MemReady handshake it carries.
interface multicycle_control_if #(
  parameter int ALUOP_WIDTH = 3
);
  logic [5:0]             OP;
  logic                   Zero;
  logic                   MemReady;
  logic                   PCWrite;
  logic                   IRWrite;
  logic                   MemRead;
  logic                   MemWrite;
  logic                   RegDst;
  logic                   RegWrite;
  logic                   MemtoReg;
  logic                   ALUSrcA;
  logic                   PCSource;
  logic [1:0]             ALUSrcB;
  logic [ALUOP_WIDTH-1:0] ALUOp;
  logic                   Busy;
  logic                   InstrDone;
  logic                   Illegal;

  modport master (
    input  OP, Zero, MemReady,
    output PCWrite, IRWrite, MemRead, MemWrite, RegDst, RegWrite, MemtoReg,
           ALUSrcA, PCSource, ALUSrcB, ALUOp, Busy, InstrDone, Illegal
  );

  modport slave (
    output OP, Zero, MemReady,
    input  PCWrite, IRWrite, MemRead, MemWrite, RegDst, RegWrite, MemtoReg,
           ALUSrcA, PCSource, ALUSrcB, ALUOp, Busy, InstrDone, Illegal
  );
endinterface

// File: rtl/mult_cycle_counter.sv
// Down-counter timing the MULT execute phase; zero is high on the last execute cycle.
// Load takes effect next clock; dec saturates at zero, no backpressure.
module mult_cycle_counter #(
  parameter int MULT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);
  localparam int CW = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(MULT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);
endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multi-cycle MIPS datapath (fetch/decode/execute/writeback, multi-cycle MULT).
// Latency 3-4 cycles per instruction (3+MULT_CYCLES for MULT); FETCH stalls while MemReady is low.
module multicycle_control
  import control_pkg::*;
#(
  parameter int ALUOP_WIDTH = 3,
  parameter int MULT_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_control_if.master bus
);
  ctrlStateT              state;
  ctrlStateT              nextState;
  logic [5:0]             opQ;
  logic                   cntLoad;
  logic                   cntDec;
  logic                   cntZero;
  ctrlSigsT               ctrl;
  logic [ALUOP_WIDTH-1:0] aluOpExt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      opQ   <= '0;
    end else begin
      state <= nextState;
      if (state == DECODE) begin
        opQ <= bus.OP;
      end
    end
  end

  assign cntLoad = (state == DECODE) && (bus.OP == MULT);
  assign cntDec  = (state == EXEC_MULT);

  mult_cycle_counter #(
    .MULT_CYCLES(MULT_CYCLES)
  ) uCounter (
    .clk  (clk),
    .reset(reset),
    .load (cntLoad),
    .dec  (cntDec),
    .zero (cntZero)
  );

  // Everything after DECODE keys off opQ so a changing OP cannot disturb the instruction in flight.
  always_comb begin
    nextState = IDLE;
    ctrl      = '0;
    case (state)
      IDLE: begin
        nextState = FETCH;
      end
      FETCH: begin
        ctrl.memRead = 1'b1;
        ctrl.aluSrcB = 2'b01;
        ctrl.aluOp   = ALU_ADD;
        ctrl.irWrite = bus.MemReady;
        ctrl.pcWrite = bus.MemReady;
        nextState    = bus.MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        ctrl.aluSrcB = 2'b11;
        ctrl.aluOp   = ALU_ADD;
        nextState    = decodeOp(bus.OP);
        ctrl.illegal = (nextState == FETCH);
      end
      EXEC_R: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluOp   = (opQ == MOV) ? ALU_MOV : ALU_RTYPE;
        nextState    = WB_R;
      end
      EXEC_I: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = 2'b10;
        ctrl.aluOp   = (opQ == ORI) ? ALU_OR : ALU_ADD;
        nextState    = WB_I;
      end
      BRANCH: begin
        ctrl.aluSrcA   = 1'b1;
        ctrl.aluOp     = ALU_SUB;
        ctrl.pcSource  = 1'b1;
        ctrl.pcWrite   = (opQ == BNE) ? ~bus.Zero : bus.Zero;
        ctrl.instrDone = 1'b1;
        nextState      = FETCH;
      end
      EXEC_MULT: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluOp   = ALU_MUL;
        ctrl.busy    = 1'b1;
        nextState    = cntZero ? WB_R : EXEC_MULT;
      end
      WB_R: begin
        ctrl.regDst    = 1'b1;
        ctrl.regWrite  = 1'b1;
        ctrl.instrDone = 1'b1;
        nextState      = FETCH;
      end
      WB_I: begin
        ctrl.regWrite  = 1'b1;
        ctrl.instrDone = 1'b1;
        nextState      = FETCH;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  always_comb begin
    aluOpExt      = '0;
    aluOpExt[2:0] = ctrl.aluOp;
  end

  assign bus.PCWrite   = ctrl.pcWrite;
  assign bus.IRWrite   = ctrl.irWrite;
  assign bus.MemRead   = ctrl.memRead;
  assign bus.MemWrite  = ctrl.memWrite;
  assign bus.RegDst    = ctrl.regDst;
  assign bus.RegWrite  = ctrl.regWrite;
  assign bus.MemtoReg  = ctrl.memtoReg;
  assign bus.ALUSrcA   = ctrl.aluSrcA;
  assign bus.PCSource  = ctrl.pcSource;
  assign bus.ALUSrcB   = ctrl.aluSrcB;
  assign bus.ALUOp     = aluOpExt;
  assign bus.Busy      = ctrl.busy;
  assign bus.InstrDone = ctrl.instrDone;
  assign bus.Illegal   = ctrl.illegal;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: two instances (MULT_CYCLES 4 and 1) driven in lockstep.
// Expected control vectors are hand-built with pk(); outputs sampled 1 time unit after the rising edge.
module tb_multicycle_control;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       memReady;
  int         nAssert = 0;
  int         nFail   = 0;

  always #5 clk = ~clk;

  multicycle_control_if #(.ALUOP_WIDTH(3)) if4 ();
  multicycle_control_if #(.ALUOP_WIDTH(4)) if1 ();

  assign if4.OP = op;  assign if4.Zero = zero;  assign if4.MemReady = memReady;
  assign if1.OP = op;  assign if1.Zero = zero;  assign if1.MemReady = memReady;

  multicycle_control #(.ALUOP_WIDTH(3), .MULT_CYCLES(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
  multicycle_control #(.ALUOP_WIDTH(4), .MULT_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  // {PCWrite,IRWrite,MemRead,MemWrite,RegDst,RegWrite,MemtoReg,ALUSrcA,PCSource,ALUSrcB,ALUOp,Busy,InstrDone,Illegal}
  function automatic logic [16:0] pk(input logic pcw, irw, mr, rd, rw, m2r, asa, pcs,
                                     input logic [1:0] asb, input logic [2:0] aop,
                                     input logic bsy, dn, ill);
    return {pcw, irw, mr, 1'b0, rd, rw, m2r, asa, pcs, asb, aop, bsy, dn, ill};
  endfunction

  function automatic logic [16:0] obs4();
    return {if4.PCWrite, if4.IRWrite, if4.MemRead, if4.MemWrite, if4.RegDst, if4.RegWrite,
            if4.MemtoReg, if4.ALUSrcA, if4.PCSource, if4.ALUSrcB, if4.ALUOp,
            if4.Busy, if4.InstrDone, if4.Illegal};
  endfunction

  function automatic logic [16:0] obs1();
    return {if1.PCWrite, if1.IRWrite, if1.MemRead, if1.MemWrite, if1.RegDst, if1.RegWrite,
            if1.MemtoReg, if1.ALUSrcA, if1.PCSource, if1.ALUSrcB, if1.ALUOp[2:0],
            if1.Busy, if1.InstrDone, if1.Illegal};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [16:0] IDLE_V, FETCH_V, STALL_V, DEC_V, DEC_ILL_V;
  logic [16:0] EXI_ADD_V, EXI_OR_V, EXR_R_V, EXR_MOV_V, EXM_V, WBI_V, WBR_V;

  // Checks FETCH, presents the opcode, checks DECODE, and leaves the FSM entering execute.
  task automatic fetchDecode(input string tag, input logic [5:0] o);
    chk({tag, "_fetch"}, obs4(), FETCH_V);
    op = o;
    step();
    chk({tag, "_decode"}, obs4(), DEC_V);
    step();
  endtask

  task automatic waitDone(input int limit, output int n);
    n = 0;
    while (!if4.InstrDone && n < limit) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    int busy4, busy1, done4, done1;
    logic [1:0] wb4, wb1;
    logic seenWrite;

    IDLE_V    = pk(0,0,0,0,0,0,0,0,2'b00,3'b000,0,0,0);
    FETCH_V   = pk(1,1,1,0,0,0,0,0,2'b01,3'b100,0,0,0);
    STALL_V   = pk(0,0,1,0,0,0,0,0,2'b01,3'b100,0,0,0);
    DEC_V     = pk(0,0,0,0,0,0,0,0,2'b11,3'b100,0,0,0);
    DEC_ILL_V = pk(0,0,0,0,0,0,0,0,2'b11,3'b100,0,0,1);
    EXI_ADD_V = pk(0,0,0,0,0,0,1,0,2'b10,3'b100,0,0,0);
    EXI_OR_V  = pk(0,0,0,0,0,0,1,0,2'b10,3'b101,0,0,0);
    EXR_R_V   = pk(0,0,0,0,0,0,1,0,2'b00,3'b111,0,0,0);
    EXR_MOV_V = pk(0,0,0,0,0,0,1,0,2'b00,3'b011,0,0,0);
    EXM_V     = pk(0,0,0,0,0,0,1,0,2'b00,3'b010,1,0,0);
    WBI_V     = pk(0,0,0,0,1,0,0,0,2'b00,3'b000,0,1,0);
    WBR_V     = pk(0,0,0,1,1,0,0,0,2'b00,3'b000,0,1,0);

    reset = 1'b0; op = 6'h08; zero = 1'b0; memReady = 1'b1;
    #1;
    chk("reset_idle", obs4(), IDLE_V);
    step(); step();
    chk("reset_held_idle", obs4(), IDLE_V);
    reset = 1'b1;
    #1;
    chk("idle_after_release", obs4(), IDLE_V);
    step();

    // ADDI walk-through: FETCH, DECODE, EXEC_I, WB_I (InstrDone on the 4th cycle)
    fetchDecode("addi", 6'h08);
    chk("addi_exec_i", obs4(), EXI_ADD_V);
    step();
    chk("addi_wb_i", obs4(), WBI_V);
    step();

    zero = 1'b1;
    fetchDecode("beq_z1", 6'h04);
    chk("beq_z1_branch", obs4(), pk(1,0,0,0,0,0,1,1,2'b00,3'b001,0,1,0));
    step();
    zero = 1'b0;
    fetchDecode("beq_z0", 6'h04);
    chk("beq_z0_branch", obs4(), pk(0,0,0,0,0,0,1,1,2'b00,3'b001,0,1,0));
    step();
    zero = 1'b1;
    fetchDecode("bne_z1", 6'h05);
    chk("bne_z1_branch", obs4(), pk(0,0,0,0,0,0,1,1,2'b00,3'b001,0,1,0));
    step();
    zero = 1'b0;
    fetchDecode("bne_z0", 6'h05);
    chk("bne_z0_branch", obs4(), pk(1,0,0,0,0,0,1,1,2'b00,3'b001,0,1,0));
    step();

    // R-type, then OP wiggled mid-execute must not change ALUOp
    fetchDecode("rtype", 6'h00);
    chk("rtype_exec_r", obs4(), EXR_R_V);
    chk("aluop_zero_ext", {28'd0, if1.ALUOp}, 32'h7);
    op = 6'h06;
    #1;
    chk("rtype_op_toggle", obs4(), EXR_R_V);
    step();
    chk("rtype_wb_r", obs4(), WBR_V);
    step();

    fetchDecode("mov", 6'h06);
    chk("mov_exec_r", obs4(), EXR_MOV_V);
    step();
    chk("mov_wb_r", obs4(), WBR_V);
    step();

    fetchDecode("ori", 6'h0D);
    chk("ori_exec_i", obs4(), EXI_OR_V);
    step();
    chk("ori_wb_i", obs4(), WBI_V);
    step();

    // Three MemReady=0 cycles in FETCH: no IR/PC write, latency grows from 4 to 7
    memReady = 1'b0;
    op = 6'h08;
    #1;
    chk("stall_c0", obs4(), STALL_V);
    step();
    chk("stall_c1", obs4(), STALL_V);
    step();
    chk("stall_c2", obs4(), STALL_V);
    step();
    memReady = 1'b1;
    #1;
    chk("stall_release", obs4(), FETCH_V);
    waitDone(20, n);
    chk("stall_latency", 4 + n, 7);
    step();

    op = 6'h3F;
    chk("illegal_fetch", obs4(), FETCH_V);
    step();
    chk("illegal_decode", obs4(), DEC_ILL_V);
    step();
    chk("illegal_back_fetch", obs4(), FETCH_V);

    // MULT on both instances: Busy width and WB_R position
    op = 6'h01;
    step();
    chk("mult_decode", obs4(), DEC_V);
    step();
    chk("mult_exec4", obs4(), EXM_V);
    chk("mult_exec1", obs1(), EXM_V);
    op = 6'h3F;
    busy4 = 0; busy1 = 0; done4 = -1; done1 = -1; wb4 = 2'b00; wb1 = 2'b00;
    for (int c = 1; c <= 8; c++) begin
      if (if4.Busy) busy4++;
      if (if1.Busy) busy1++;
      if (if4.InstrDone && done4 < 0) begin done4 = c; wb4 = {if4.RegWrite, if4.RegDst}; end
      if (if1.InstrDone && done1 < 0) begin done1 = c; wb1 = {if1.RegWrite, if1.RegDst}; end
      step();
    end
    chk("mult4_busy_cycles", busy4, 4);
    chk("mult1_busy_cycles", busy1, 1);
    chk("mult4_done_cycle", done4, 5);
    chk("mult1_done_cycle", done1, 2);
    chk("mult4_wb_r", {30'd0, wb4}, 32'h3);
    chk("mult1_wb_r", {30'd0, wb1}, 32'h3);

    // Async reset in the 2nd EXEC_MULT cycle aborts the MULT
    reset = 1'b0;
    #1;
    chk("resync_idle", obs1(), IDLE_V);
    step();
    reset = 1'b1;
    step();
    chk("rst_mult_fetch", obs4(), FETCH_V);
    op = 6'h01;
    step();
    step();
    step();
    chk("rst_mult_cycle2", obs4(), EXM_V);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", obs4(), IDLE_V);
    seenWrite = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (if4.RegWrite || if4.PCWrite) seenWrite = 1'b1;
    end
    chk("no_write_in_reset", {31'd0, seenWrite}, 32'h0);
    op = 6'h3F;
    reset = 1'b1;
    step();
    chk("after_abort_fetch", obs4(), FETCH_V);
    step();
    chk("after_abort_no_wb", obs4(), DEC_ILL_V);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
